adc_multi_capture: RTL and testbench

//  Parametrised N-channel capture engine for LTC2315-class serial ADCs.

---
 rtl/adc_multi_capture.sv | 212 +++++++++++++++++++++
 tb/tb_adc_multi_capture.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_multi_capture.sv
// -----------------------------------------------------------------------------
// adc_multi_capture
//   N-channel capture engine for LTC2315-class serial ADCs. All channels share
//   one chip select and one serial clock; each channel has its own data line.
//   A fixed-rate frame shifts in 16 bits per channel, unpacks the 12-bit result
//   from frame[13:2], flags frame[15:14] != 0 as a framing error, and emits an
//   index-tagged sample plus a block-complete strobe every BLOCK_LEN samples.
//
//   Optional build macro: ADC_TEST_PATTERN_EN
//     When defined, sdo is ignored and channel i reports (ramp + i) mod 4096,
//     where ramp counts delivered samples from 0. SPI timing is unchanged and
//     err_count stays 0.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active high
//   start        in   run enable, level-sensitive
//   sdo          in   [N_CH]      serial data, bit i = channel i
//   sck          out  serial clock, idles low
//   cs           out  chip select, active low
//   smp_data     out  [N_CH*16]   per channel {4'd0, 12-bit}, ch0 in [15:0]
//   smp_valid    out  1-cycle strobe qualifying smp_data / smp_index
//   smp_index    out  [IDX_W]     sample position within its block
//   block_ready  out  1-cycle pulse with the sample at index BLOCK_LEN-1
//   err_count    out  [N_CH*8]    per-channel saturating framing-error count
//   busy         out  high while frames are running
// -----------------------------------------------------------------------------
module adc_multi_capture #(
   parameter int N_CH       = 2,
   parameter int SCK_HALF   = 2,
   parameter int FRAME_CLKS = 100,
   parameter int BLOCK_LEN  = 256,
   parameter int IDX_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [N_CH-1:0]      sdo,
   output logic                 sck,
   output logic                 cs,
   output logic [N_CH*16-1:0]   smp_data,
   output logic                 smp_valid,
   output logic [IDX_W-1:0]     smp_index,
   output logic                 block_ready,
   output logic [N_CH*8-1:0]    err_count,
   output logic                 busy
);

   localparam int TW = $clog2(FRAME_CLKS);
   localparam logic [TW-1:0] T_SHIFT_LAST = TW'(32*SCK_HALF - 1);
   localparam logic [TW-1:0] T_LATCH      = TW'(32*SCK_HALF);
   localparam logic [TW-1:0] T_KEEP_END   = TW'(28*SCK_HALF);
   localparam logic [TW-1:0] T_FRAME_LAST = TW'(FRAME_CLKS - 1);
   localparam logic [TW-1:0] BIT_CLKS     = TW'(2*SCK_HALF);
   localparam logic [TW-1:0] HALF_CLKS    = TW'(SCK_HALF);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BLOCK_LEN - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t                      state_q, state_d;
   logic [TW-1:0]               t_q, t_d;
   logic                        cs_q, cs_d;
   logic                        sck_q, sck_d;
   logic                        busy_q, busy_d;
   // Only the first 14 bits of a frame matter (frame[15:2]); the two trailing
   // bits are clocked out by the ADC but never kept.
   logic [N_CH-1:0][13:0]       sh_q, sh_d;
   logic [N_CH-1:0][15:0]       smp_data_q, smp_data_d;
   logic                        smp_valid_q, smp_valid_d;
   logic [IDX_W-1:0]            smp_index_q, smp_index_d;
   logic                        block_ready_q, block_ready_d;
   logic [N_CH-1:0][7:0]        err_q, err_d;
   logic [IDX_W-1:0]            next_idx_q, next_idx_d;
`ifdef ADC_TEST_PATTERN_EN
   logic [11:0]                 ramp_q, ramp_d;
`endif

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
      end
   end

   // Next-state and frame timer.
   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      unique case (state_q)
         IDLE: begin
            t_d = '0;
            if (start) state_d = SHIFT;
         end
         SHIFT: begin
            t_d = t_q + TW'(1);
            if (t_q == T_SHIFT_LAST) state_d = GAP;
         end
         GAP: begin
            if (t_q == T_FRAME_LAST) begin
               t_d     = '0;
               state_d = start ? SHIFT : IDLE;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            t_d     = '0;
         end
      endcase
   end

   // Outputs and datapath. SPI pins are derived from the next state/timer so
   // the registered pins line up with state_q/t_q in the same cycle.
   always_comb begin
      cs_d          = (state_d != SHIFT);
      sck_d         = (state_d == SHIFT) && ((t_d % BIT_CLKS) >= HALF_CLKS);
      busy_d        = (state_d != IDLE);
      sh_d          = sh_q;
      smp_data_d    = smp_data_q;
      smp_valid_d   = 1'b0;
      smp_index_d   = smp_index_q;
      block_ready_d = 1'b0;
      err_d         = err_q;
      next_idx_d    = next_idx_q;
`ifdef ADC_TEST_PATTERN_EN
      ramp_d        = ramp_q;
`endif

      // A restart always begins a fresh block; any partial block is dropped.
      if (state_q == IDLE) begin
         next_idx_d = '0;
`ifdef ADC_TEST_PATTERN_EN
         ramp_d     = '0;
`endif
      end

      // Sample sdo in the cycle sck is first high (MSB first).
      if (state_q == SHIFT && (t_q % BIT_CLKS) == HALF_CLKS && t_q < T_KEEP_END) begin
         for (int i = 0; i < N_CH; i++) sh_d[i] = {sh_q[i][12:0], sdo[i]};
      end

      if (state_q == GAP && t_q == T_LATCH) begin
         smp_valid_d   = 1'b1;
         smp_index_d   = next_idx_q;
         block_ready_d = (next_idx_q == IDX_LAST);
         next_idx_d    = next_idx_q + IDX_W'(1);
`ifdef ADC_TEST_PATTERN_EN
         for (int i = 0; i < N_CH; i++) smp_data_d[i] = {4'd0, ramp_q + 12'(i)};
         ramp_d = ramp_q + 12'd1;
`else
         for (int i = 0; i < N_CH; i++) begin
            smp_data_d[i] = {4'd0, sh_q[i][11:0]};
            // sh_q[i][13:12] holds frame[15:14]; both must be zero.
            if (sh_q[i][13:12] != 2'b00 && err_q[i] != 8'hFF) err_d[i] = err_q[i] + 8'd1;
         end
`endif
      end
   end

   // NOTE: every register here is a plain flop (no memory array), so all of
   // them take a reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_q          <= 1'b1;
         sck_q         <= 1'b0;
         busy_q        <= 1'b0;
         sh_q          <= '0;
         smp_data_q    <= '0;
         smp_valid_q   <= 1'b0;
         smp_index_q   <= '0;
         block_ready_q <= 1'b0;
         err_q         <= '0;
         next_idx_q    <= '0;
`ifdef ADC_TEST_PATTERN_EN
         ramp_q        <= '0;
`endif
      end else begin
         cs_q          <= cs_d;
         sck_q         <= sck_d;
         busy_q        <= busy_d;
         sh_q          <= sh_d;
         smp_data_q    <= smp_data_d;
         smp_valid_q   <= smp_valid_d;
         smp_index_q   <= smp_index_d;
         block_ready_q <= block_ready_d;
         err_q         <= err_d;
         next_idx_q    <= next_idx_d;
`ifdef ADC_TEST_PATTERN_EN
         ramp_q        <= ramp_d;
`endif
      end
   end

   assign cs          = cs_q;
   assign sck         = sck_q;
   assign busy        = busy_q;
   assign smp_data    = smp_data_q;
   assign smp_valid   = smp_valid_q;
   assign smp_index   = smp_index_q;
   assign block_ready = block_ready_q;
   assign err_count   = err_q;

endmodule

// File: tb/tb_adc_multi_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_multi_capture
//   Directed bench for adc_multi_capture (N_CH=2, SCK_HALF=2, FRAME_CLKS=100,
//   BLOCK_LEN=256). An ADC model serves each channel's model word on sdo and
//   pushes the expected sample to a scoreboard queue when cs falls; a monitor
//   pops and compares on every smp_valid.
//   Model word layout: [15:14] leading bits, [11:0] conversion result. On the
//   wire this becomes {lead, result, 2'b00}, so the result lands in frame[13:2].
// -----------------------------------------------------------------------------
module tb_adc_multi_capture;

   localparam int N_CH       = 2;
   localparam int SCK_HALF   = 2;
   localparam int FRAME_CLKS = 100;
   localparam int BLOCK_LEN  = 256;
   localparam int IDX_W      = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [N_CH-1:0]      sdo;
   logic                 sck;
   logic                 cs;
   logic [N_CH*16-1:0]   smp_data;
   logic                 smp_valid;
   logic [IDX_W-1:0]     smp_index;
   logic                 block_ready;
   logic [N_CH*8-1:0]    err_count;
   logic                 busy;

   adc_multi_capture #(
      .N_CH(N_CH), .SCK_HALF(SCK_HALF), .FRAME_CLKS(FRAME_CLKS),
      .BLOCK_LEN(BLOCK_LEN), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .sdo(sdo), .sck(sck), .cs(cs),
      .smp_data(smp_data), .smp_valid(smp_valid), .smp_index(smp_index),
      .block_ready(block_ready), .err_count(err_count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N_CH*16-1:0] data;
      logic [IDX_W-1:0]   idx;
      logic               br;
      logic [N_CH*8-1:0]  err;
      longint             fall;
   } exp_t;

   int          total = 0;
   int          bad   = 0;
   longint      cyc   = 0;
   exp_t        q[$];
   logic [15:0] word [N_CH];
   int          m_idx;
   logic [11:0] m_ramp;
   logic [7:0]  m_err [N_CH];
   int          valid_cnt = 0;
   int          br_cnt = 0;
   int          fall_cnt = 0;
   int          last_rises = 0;
   int          idx_after_br = -1;
   longint      last_valid_cyc = 0;
   logic [N_CH*16-1:0] last_data = '0;
   logic [IDX_W-1:0]   last_index = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic wait_valids(input int n, input int budget);
      int target = valid_cnt + n;
      int k = 0;
      while (valid_cnt < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("wait_valid", 64'(valid_cnt >= target), 64'(1));
   endtask

   task automatic wait_cs_fall(input int budget);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (cs !== 1'b0 && k < budget);
      check("wait_cs_fall", 64'(cs), 64'(0));
   endtask

   task automatic model_restart();
      m_idx  = 0;
      m_ramp = '0;
   endtask

   // ADC model: shifts the frame snapshot out, one bit per sck period, and
   // pushes the expected sample when the frame starts.
   initial begin : adc_model
      logic        cs_p = 1'b1;
      logic        sck_p = 1'b0;
      int          bitn = 0;
      int          rises = 0;
      logic [15:0] snap [N_CH];
      exp_t        e;
      for (int i = 0; i < N_CH; i++) snap[i] = '0;
      sdo = '0;
      forever begin
         @(negedge clk);
         if (cs_p && !cs) begin
            fall_cnt++;
            bitn  = 0;
            rises = 0;
            e.fall = cyc;
            e.idx  = IDX_W'(m_idx);
            e.br   = (m_idx == BLOCK_LEN - 1);
            for (int i = 0; i < N_CH; i++) begin
               snap[i] = {word[i][15:14], word[i][11:0], 2'b00};
`ifdef ADC_TEST_PATTERN_EN
               e.data[i*16 +: 16] = {4'd0, m_ramp + 12'(i)};
`else
               e.data[i*16 +: 16] = {4'd0, word[i][11:0]};
               if (word[i][15:14] != 2'b00 && m_err[i] != 8'hFF) m_err[i] = m_err[i] + 8'd1;
`endif
               e.err[i*8 +: 8] = m_err[i];
            end
            m_idx  = (m_idx + 1) % BLOCK_LEN;
            m_ramp = m_ramp + 12'd1;
            q.push_back(e);
         end
         if (!cs) begin
            if (!sck_p && sck) rises++;
            if (sck_p && !sck) bitn++;
         end
         if (!cs_p && cs) last_rises = rises;
         for (int i = 0; i < N_CH; i++) sdo[i] = (!cs && bitn < 16) ? snap[i][15 - bitn] : 1'b0;
         cs_p  = cs;
         sck_p = sck;
      end
   end

   // Monitor: pops one expectation per smp_valid.
   initial begin : monitor
      exp_t e;
      logic prev_br = 1'b0;
      forever begin
         @(negedge clk);
         if (block_ready) check("br_with_valid", 64'(smp_valid), 64'(1));
         if (smp_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            last_data      = smp_data;
            last_index     = smp_index;
            if (block_ready) br_cnt++;
            if (prev_br) idx_after_br = int'(smp_index);
            prev_br = block_ready;
            check("valid_expected", 64'(q.size() > 0), 64'(1));
            if (q.size() > 0) begin
               e = q.pop_front();
               check("smp_data",    64'(smp_data),    64'(e.data));
               check("smp_index",   64'(smp_index),   64'(e.idx));
               check("block_ready", 64'(block_ready), 64'(e.br));
               check("err_count",   64'(err_count),   64'(e.err));
               check("latency",     64'(cyc - e.fall), 64'(32*SCK_HALF + 1));
               check("sck_rises",   64'(last_rises),  64'(16));
            end
         end
      end
   end

   initial begin : main
      longint c0;
      int     fc, vc, bc;
      rst   = 1'b1;
      start = 1'b0;
      model_restart();
      for (int i = 0; i < N_CH; i++) begin
         word[i]  = '0;
         m_err[i] = '0;
      end
      repeat (3) @(negedge clk);

      // Reset state.
      check("rst_cs",          64'(cs),          64'(1));
      check("rst_sck",         64'(sck),         64'(0));
      check("rst_smp_valid",   64'(smp_valid),   64'(0));
      check("rst_block_ready", 64'(block_ready), 64'(0));
      check("rst_busy",        64'(busy),        64'(0));
      check("rst_err_count",   64'(err_count),   64'(0));
      check("rst_smp_index",   64'(smp_index),   64'(0));
      check("rst_smp_data",    64'(smp_data),    64'(0));
      rst = 1'b0;

      // Clean frames: data, latency, period.
      word[0] = 16'h0ABC;
      word[1] = 16'h0123;
      @(negedge clk);
      start = 1'b1;
      wait_cs_fall(10);
      check("busy_running", 64'(busy), 64'(1));
      wait_valids(1, 200);
`ifndef ADC_TEST_PATTERN_EN
      check("data_clean", 64'(last_data), 64'(32'h0123_0ABC));
`endif
      c0 = last_valid_cyc;
      wait_valids(1, 200);
      check("frame_period", 64'(last_valid_cyc - c0), 64'(FRAME_CLKS));
      wait_valids(1, 200);

      // ch1 framing errors over 300 frames; crosses one block boundary.
      word[1] = 16'hC555;
      wait_valids(300, 300*FRAME_CLKS + 300);
`ifdef ADC_TEST_PATTERN_EN
      check("err_saturated", 64'(err_count), 64'(0));
`else
      check("err_saturated", 64'(err_count), 64'(16'hFF00));
      check("data_err_ch1",  64'(last_data), 64'(32'h0555_0ABC));
`endif
      check("block_once",   64'(br_cnt),       64'(1));
      check("idx_after_br", 64'(idx_after_br), 64'(0));

      // start falls at t=10: the frame completes, then idle.
      wait_cs_fall(200);
      repeat (10) @(negedge clk);
      start = 1'b0;
      fc = fall_cnt;
      vc = valid_cnt;
      wait_valids(1, 200);
      check("stop_queue_empty", 64'(q.size()), 64'(0));
      repeat (60) @(negedge clk);
      check("stop_busy",      64'(busy),      64'(0));
      check("stop_cs",        64'(cs),        64'(1));
      check("stop_sck",       64'(sck),       64'(0));
      check("stop_no_frame",  64'(fall_cnt),  64'(fc));
      check("stop_one_valid", 64'(valid_cnt), 64'(vc + 1));

      // Restart: new block from index 0, no block_ready.
      model_restart();
      bc = br_cnt;
      start = 1'b1;
      wait_valids(1, 300);
      check("restart_index", 64'(last_index), 64'(0));
      check("restart_no_br", 64'(br_cnt),     64'(bc));

      // Reset at t=30 of a frame.
      wait_cs_fall(200);
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_cs",    64'(cs),        64'(1));
      check("abort_sck",   64'(sck),       64'(0));
      check("abort_index", 64'(smp_index), 64'(0));
      check("abort_busy",  64'(busy),      64'(0));
      start = 1'b0;
      q.delete();
      model_restart();
      for (int i = 0; i < N_CH; i++) m_err[i] = '0;
      vc = valid_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (120) @(negedge clk);
      check("abort_no_valid", 64'(valid_cnt), 64'(vc));
      check("abort_err_clr",  64'(err_count), 64'(0));
      start = 1'b1;
      wait_valids(1, 300);
      check("post_abort_index", 64'(last_index), 64'(0));
      start = 1'b0;
      repeat (150) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
